// File: rtl/obstacle_pool.sv
// Obstacle pool: spawns, scrolls and retires up to NUM_OBS obstacle
// channels under an IDLE/RUN/HALT game-state machine.
module obstacle_pool #(
  parameter int NUM_OBS = 2,
  parameter int CONV    = 2,
  parameter int SPAWN_X = 160,
  parameter int MIN_GAP = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           game_start,
  input  logic                           game_frozen,
  input  logic                           game_tick,
  input  logic [7:0]                     rng,
  input  logic [1:0]                     speed,
  output logic [NUM_OBS*(10-CONV)-1:0]   obs_pos,
  output logic [NUM_OBS*3-1:0]           obs_type,
  output logic [NUM_OBS-1:0]             obs_active,
  output logic                           spawn_pulse
);

  localparam int POS_W = 10 - CONV;
  localparam logic [POS_W-1:0] ALL1  = '1;
  localparam logic [POS_W-1:0] SPAWN = POS_W'(SPAWN_X);
  localparam logic [8:0]       GAP0  = 9'(MIN_GAP);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t              state, state_d;
  logic [POS_W-1:0]    pos_q [NUM_OBS];
  logic [POS_W-1:0]    pos_d [NUM_OBS];
  logic [2:0]          typ_q [NUM_OBS];
  logic [2:0]          typ_d [NUM_OBS];
  logic [NUM_OBS-1:0]  act_q, act_d;
  logic [8:0]          gap_q, gap_d;
  logic                pulse_q, pulse_d;
  logic [POS_W-1:0]    step;
  logic [2:0]          new_typ;
  logic [9:0]          reload;
  logic                found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      act_q   <= '0;
      gap_q   <= GAP0;
      pulse_q <= 1'b0;
      for (int i = 0; i < NUM_OBS; i++) begin
        pos_q[i] <= ALL1;
        typ_q[i] <= 3'd0;
      end
    end else begin
      state   <= state_d;
      act_q   <= act_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_OBS; i++) begin
        pos_q[i] <= pos_d[i];
        typ_q[i] <= typ_d[i];
      end
    end
  end

  always_comb begin
    step    = POS_W'(speed) + POS_W'(1);
    new_typ = (rng[2:0] < 3'd6) ? rng[2:0] : {1'b0, rng[1:0]};
    reload  = 10'(MIN_GAP) + {5'd0, rng[4:3], 3'd0};
    state_d = state;
    act_d   = act_q;
    gap_d   = gap_q;
    pulse_d = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      pos_d[i] = pos_q[i];
      typ_d[i] = typ_q[i];
    end
    if (game_start) begin
      state_d = RUN;
      act_d   = '0;
      gap_d   = GAP0;
      for (int i = 0; i < NUM_OBS; i++) begin
        pos_d[i] = ALL1;
        typ_d[i] = 3'd0;
      end
    end else if (state == RUN && game_frozen) begin
      state_d = HALT;
    end else if (state == RUN && game_tick) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (act_q[i]) begin
          if (pos_q[i] >= step) begin
            pos_d[i] = pos_q[i] - step;
          end else begin
            act_d[i] = 1'b0;
            pos_d[i] = ALL1;
          end
        end
      end
      // free slots are judged on pre-tick occupancy so a retiree waits a tick
      if (gap_q != 9'd0) begin
        gap_d = gap_q - 9'd1;
      end else if (rng[7:5] != 3'd0) begin
        for (int i = 0; i < NUM_OBS; i++) begin
          if (!act_q[i] && !found) begin
            found    = 1'b1;
            act_d[i] = 1'b1;
            pos_d[i] = SPAWN;
            typ_d[i] = new_typ;
          end
        end
        if (found) begin
          gap_d   = reload[9] ? 9'h1FF : reload[8:0];
          pulse_d = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_out
    assign obs_pos[g*POS_W +: POS_W] = pos_q[g];
    assign obs_type[g*3 +: 3]        = typ_q[g];
  end

  assign obs_active  = act_q;
  assign spawn_pulse = pulse_q;

endmodule

// File: tb/tb_obstacle_pool.sv
// Bench for obstacle_pool: directed scenarios plus random traffic
// checked against an array-based game model.
module tb_obstacle_pool;

  localparam int N  = 2;
  localparam int PW = 8;
  localparam int SX = 160;
  localparam int MG = 24;
  localparam int AO = (1 << PW) - 1;
  localparam int W  = N*PW + N*3 + N + 1;
  localparam logic [W-1:0] CLR = {{(N*PW){1'b1}}, {(N*3){1'b0}}, {N{1'b0}}, 1'b0};

  logic clk = 1'b0;
  logic rst, game_start, game_frozen, game_tick;
  logic [7:0] rng;
  logic [1:0] speed;
  wire [N*PW-1:0] obs_pos;
  wire [N*3-1:0]  obs_type;
  wire [N-1:0]    obs_active;
  wire            spawn_pulse;
  wire [W-1:0]    got = {obs_pos, obs_type, obs_active, spawn_pulse};

  obstacle_pool dut (
    .clk(clk), .rst(rst), .game_start(game_start),
    .game_frozen(game_frozen), .game_tick(game_tick),
    .rng(rng), .speed(speed), .obs_pos(obs_pos),
    .obs_type(obs_type), .obs_active(obs_active),
    .spawn_pulse(spawn_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 running, 2 halted
  int m_st;
  int m_gap;
  int m_pos [N];
  bit m_act [N];
  int m_typ [N];
  bit m_pulse;
  logic [W-1:0] expv;

  function automatic void m_pack();
    logic [N*PW-1:0] p;
    logic [N*3-1:0] t;
    logic [N-1:0] a;
    for (int i = 0; i < N; i++) begin
      p[i*PW +: PW] = PW'(m_pos[i]);
      t[i*3 +: 3] = 3'(m_typ[i]);
      a[i] = m_act[i];
    end
    expv = {p, t, a, m_pulse};
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0;
      m_pos[i] = AO;
      m_typ[i] = 0;
    end
    m_gap = MG;
    m_pulse = 0;
  endfunction

  function automatic void m_step(bit s, bit f, bit t, logic [7:0] r, int spd);
    int free;
    int st;
    int g;
    m_pulse = 0;
    free = -1;
    st = spd + 1;
    if (s) begin
      m_clear();
      m_st = 1;
    end else if (m_st == 1 && f) begin
      m_st = 2;
    end else if (m_st == 1 && t) begin
      for (int i = 0; i < N; i++)
        if (!m_act[i] && free < 0) free = i;
      for (int i = 0; i < N; i++) begin
        if (m_act[i]) begin
          if (m_pos[i] >= st) m_pos[i] -= st;
          else begin
            m_act[i] = 0;
            m_pos[i] = AO;
          end
        end
      end
      if (m_gap > 0) m_gap--;
      else if (r[7:5] != 0 && free >= 0) begin
        m_act[free] = 1;
        m_pos[free] = SX;
        m_typ[free] = (r[2:0] < 6) ? int'(r[2:0]) : int'(r[1:0]);
        g = MG + 8 * int'(r[4:3]);
        m_gap = (g > 511) ? 511 : g;
        m_pulse = 1;
      end
    end
    m_pack();
  endfunction

  task automatic cyc(bit s, bit f, bit t, logic [7:0] r, logic [1:0] spd);
    game_start = s;
    game_frozen = f;
    game_tick = t;
    rng = r;
    speed = spd;
    @(posedge clk);
    m_step(s, f, t, r, int'(spd));
    #1;
  endtask

  task automatic ticks(int n, logic [7:0] r, logic [1:0] spd);
    for (int k = 0; k < n; k++) cyc(0, 0, 1, r, spd);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    game_start = 0; game_frozen = 0; game_tick = 0;
    rng = 0; speed = 0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (got !== CLR) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", got, CLR);
    end
    @(posedge clk);
    #1;
    game_tick = 1'b1;
    rst = 1'b0;
    m_clear();
    m_st = 0;
    m_pack();
  endtask

  task automatic test_idle_ticks();
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 1, 8'hE5, 2'($urandom));
      checks++;
      if (got !== CLR || got !== expv) begin
        failures++;
        $display("FAIL idle_ticks got=%h exp=%h", got, CLR);
      end
    end
  endtask

  task automatic test_first_spawn();
    cyc(1, 0, 0, 8'hE5, 0);
    checks++;
    if (got !== CLR) begin
      failures++;
      $display("FAIL start_clear got=%h exp=%h", got, CLR);
    end
    for (int k = 1; k <= 24; k++) begin
      cyc(0, 0, 1, 8'hE5, 0);
      cyc(0, 0, 0, 8'hE5, 3);
      checks++;
      if (obs_active !== 2'b00 || got !== expv) begin
        failures++;
        $display("FAIL gap_wait tick=%0d got=%h exp=%h", k, got, expv);
      end
    end
    cyc(0, 0, 1, 8'hE5, 0);
    checks++;
    if (obs_active !== 2'b01 || obs_pos[PW-1:0] !== 8'd160 ||
        obs_type[2:0] !== 3'd5 || spawn_pulse !== 1'b1) begin
      failures++;
      $display("FAIL first_spawn got=%h exp act=01 pos=a0 type=5 pulse=1", got);
    end
    cyc(0, 0, 0, 8'hE5, 0);
    checks++;
    if (spawn_pulse !== 1'b0 || got !== expv) begin
      failures++;
      $display("FAIL pulse_width got=%h exp=%h", got, expv);
    end
    ticks(24, 8'hE5, 0);
    checks++;
    if (obs_active !== 2'b01 || obs_pos[PW-1:0] !== 8'd136) begin
      failures++;
      $display("FAIL gap_reload got=%h exp act=01 pos0=88", got);
    end
  endtask

  task automatic test_retire();
    cyc(1, 0, 0, 8'hE5, 0);
    ticks(25, 8'hE5, 0);
    ticks(79, 8'h05, 1);
    checks++;
    if (obs_active !== 2'b01 || obs_pos[PW-1:0] !== 8'd2) begin
      failures++;
      $display("FAIL retire_pre got=%h exp act=01 pos0=02", got);
    end
    cyc(0, 0, 1, 8'h05, 3);
    checks++;
    if (obs_active !== 2'b00 || obs_pos[PW-1:0] !== 8'hFF ||
        obs_type[2:0] !== 3'd5 || got !== expv) begin
      failures++;
      $display("FAIL retire got=%h exp=%h", got, expv);
    end
  endtask

  task automatic test_full_pool();
    int n;
    cyc(1, 0, 0, 8'hE5, 0);
    ticks(25, 8'hE5, 0);
    ticks(25, 8'hE6, 0);
    checks++;
    if (obs_active !== 2'b11 || obs_type[5:3] !== 3'd2 ||
        obs_pos[2*PW-1:PW] !== 8'd160 || obs_pos[PW-1:0] !== 8'd135) begin
      failures++;
      $display("FAIL second_spawn got=%h exp act=11 t1=2 p1=a0 p0=87", got);
    end
    ticks(24, 8'hE5, 0);
    cyc(0, 0, 1, 8'hE5, 0);
    checks++;
    if (spawn_pulse !== 1'b0 || obs_active !== 2'b11 || got !== expv) begin
      failures++;
      $display("FAIL pool_full got=%h exp=%h", got, expv);
    end
    n = 0;
    while (m_act[0] && n < 60) begin
      cyc(0, 0, 1, 8'hE5, 3);
      n++;
    end
    checks++;
    if (m_act[0] || obs_active !== 2'b10 || spawn_pulse !== 1'b0 ||
        got !== expv) begin
      failures++;
      $display("FAIL retire_no_reuse n=%0d got=%h exp=%h", n, got, expv);
    end
    cyc(0, 0, 1, 8'hE5, 3);
    checks++;
    if (obs_active !== 2'b11 || spawn_pulse !== 1'b1 ||
        obs_pos[PW-1:0] !== 8'd160 || got !== expv) begin
      failures++;
      $display("FAIL respawn got=%h exp=%h", got, expv);
    end
  endtask

  task automatic test_frozen();
    logic [W-1:0] snap;
    cyc(1, 0, 0, 8'hE5, 0);
    ticks(28, 8'hE5, 0);
    snap = expv;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 1, 8'($urandom), 2'($urandom));
      checks++;
      if (got !== snap) begin
        failures++;
        $display("FAIL frozen k=%0d got=%h exp=%h", k, got, snap);
      end
    end
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, 8'hE5, 0);
      checks++;
      if (got !== snap) begin
        failures++;
        $display("FAIL halt_hold k=%0d got=%h exp=%h", k, got, snap);
      end
    end
    cyc(1, 0, 0, 8'hE5, 0);
    checks++;
    if (got !== CLR) begin
      failures++;
      $display("FAIL halt_restart got=%h exp=%h", got, CLR);
    end
    ticks(25, 8'hE5, 0);
    checks++;
    if (spawn_pulse !== 1'b1 || obs_active !== 2'b01) begin
      failures++;
      $display("FAIL resume_run got=%h exp pulse=1 act=01", got);
    end
  endtask

  task automatic test_start_tick();
    cyc(1, 0, 0, 8'hE5, 0);
    ticks(27, 8'hE5, 0);
    cyc(1, 0, 1, 8'hE5, 3);
    checks++;
    if (got !== CLR) begin
      failures++;
      $display("FAIL start_tick got=%h exp=%h", got, CLR);
    end
    ticks(24, 8'hE5, 0);
    checks++;
    if (obs_active !== 2'b00) begin
      failures++;
      $display("FAIL start_tick_gap got=%h exp act=00", got);
    end
    cyc(0, 0, 1, 8'hE5, 0);
    checks++;
    if (spawn_pulse !== 1'b1 || got !== expv) begin
      failures++;
      $display("FAIL start_tick_spawn got=%h exp=%h", got, expv);
    end
  endtask

  task automatic test_reset_midgame();
    cyc(1, 0, 0, 8'hE5, 0);
    ticks(30, 8'hE5, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (got !== CLR) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", got, CLR);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_clear();
    m_st = 0;
    m_pack();
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, 1, 8'hE5, 0);
      checks++;
      if (got !== CLR || got !== expv) begin
        failures++;
        $display("FAIL post_reset k=%0d got=%h exp=%h", k, got, CLR);
      end
    end
  endtask

  task automatic test_random();
    bit s, f, t;
    cyc(1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 3000; k++) begin
      s = ($urandom_range(199) == 0);
      f = ($urandom_range(249) == 0);
      t = ($urandom_range(2) != 0);
      cyc(s, f, t, 8'($urandom), 2'($urandom));
      checks++;
      if (got !== expv) begin
        failures++;
        $display("FAIL random k=%0d got=%h exp=%h", k, got, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ticks();
    test_first_spawn();
    test_retire();
    test_full_pool();
    test_frozen();
    test_start_tick();
    test_reset_midgame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obstacle_pool.md
OBSTACLE_POOL -- requirements
Module: obstacle_pool

Interface
REQ-001 The block SHALL have parameter NUM_OBS, default 2, number of obstacle channels (legal 1..4).
REQ-002 The block SHALL have parameter CONV, default 2, pixel-coarsening shift; POS_W = 10-CONV.
REQ-003 The block SHALL have parameter SPAWN_X, default 160, spawn position in coarse pixels.
REQ-004 The block SHALL have parameter MIN_GAP, default 24, minimum ticks between spawns (1..255).
REQ-005 The block SHALL have port clk input 1, sole clock.
REQ-006 The block SHALL have port rst input 1, asynchronous active-high reset.
REQ-007 The block SHALL have port game_start input 1, one-cycle pulse, (re)starts the game.
REQ-008 The block SHALL have port game_frozen input 1, level, halts all motion and spawning.
REQ-009 The block SHALL have port game_tick input 1, one-cycle motion strobe.
REQ-010 The block SHALL have port rng input 8, free-running random byte.
REQ-011 The block SHALL have port speed input 2, step per tick = speed+1 coarse pixels.
REQ-012 The block SHALL have port obs_pos output NUM_OBS*POS_W, channel i at bits [i*POS_W +: POS_W].
REQ-013 The block SHALL have port obs_type output NUM_OBS*3, channel i at bits [i*3 +: 3].
REQ-014 The block SHALL have port obs_active output NUM_OBS, 1 = channel on screen.
REQ-015 The block SHALL have port spawn_pulse output 1, high one cycle when a channel spawns.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HALT; reset enters IDLE.
REQ-017 IDLE -> RUN on game_start; RUN -> HALT when game_frozen=1; HALT -> RUN on game_start only.
REQ-018 game_start in any state SHALL, next cycle: all obs_active=0, all obs_pos=all-ones, all obs_type=0, gap counter=MIN_GAP.
REQ-019 game_start SHALL take priority over a coincident game_tick; that tick is discarded.
REQ-020 Only in RUN with game_tick=1 and game_frozen=0 SHALL positions, gap counter or spawns change; otherwise all state holds.
REQ-021 On a valid tick each active channel with pos >= step SHALL update to pos-step; with pos < step it SHALL become inactive with pos all-ones (no wrap-around).
REQ-022 On a valid tick a nonzero gap counter SHALL decrement by 1.
REQ-023 On a valid tick with gap counter 0 and rng[7:5] != 0, the lowest-indexed channel inactive before this tick SHALL spawn: active=1, pos=SPAWN_X, type=rng[2:0] if <6 else rng[1:0].
REQ-024 On spawn the gap counter SHALL load MIN_GAP + 8*rng[4:3] (9-bit, saturating at 511), and spawn_pulse SHALL be 1 for that cycle.
REQ-025 If gap counter is 0 but no channel is free or rng[7:5]==0, no spawn SHALL occur; counter stays 0 and spawning retries next valid tick.
REQ-026 A channel retiring on a tick SHALL NOT be reused in that same tick.
REQ-027 All outputs SHALL be registered; effects of a tick or game_start SHALL appear exactly one cycle after the strobe cycle.
REQ-028 speed SHALL be sampled on the tick cycle; changes between ticks have no effect.
REQ-029 Inactive channels SHALL always present pos all-ones and hold their last type.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, obs_active=0, obs_pos=all-ones, obs_type=0, spawn_pulse=0, gap counter=MIN_GAP.
REQ-031 Reset asserted mid-game SHALL discard all channels; release SHALL require game_start before any spawn.
REQ-032 Release of rst SHALL be sampled synchronously; no tick in the release cycle takes effect.

Verification
REQ-033 Reset, then 10 ticks without game_start -> obs_active=0, spawn_pulse never asserted.
REQ-034 game_start, MIN_GAP=24, rng=8'hE5 held, speed=0 -> after 24 ticks, tick 25 spawns ch0 pos=160 type=5 active; gap reloads 24.
REQ-035 One active ch0 pos=2, speed=3 (step 4), tick -> ch0 inactive, pos=all-ones, no underflow.
REQ-036 NUM_OBS=2, both active, gap counter 0, rng[7:5]!=0, tick -> no spawn; next tick after a retirement -> spawn into freed channel.
REQ-037 game_frozen=1 for 20 ticks -> all outputs constant, FSM HALT; game_start -> cleared, RUN.
REQ-038 game_start and game_tick same cycle with ch0 active -> next cycle all channels inactive, gap=MIN_GAP, no movement.
